// File: rtl/alu_pkg.sv
// Shared definitions for the nibble-serial 32-bit ALU: op codes, FSM states and slice decode.
package alu_pkg;

    localparam int unsigned NIBBLES = 8;

    localparam logic [3:0] AluAnd = 4'b0000;
    localparam logic [3:0] AluOr  = 4'b0001;
    localparam logic [3:0] AluAdd = 4'b0010;
    localparam logic [3:0] AluSub = 4'b0110;
    localparam logic [3:0] AluSlt = 4'b0111;
    localparam logic [3:0] AluNor = 4'b1100;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

    typedef struct packed {
        logic       a_invert;
        logic       b_invert;
        logic [1:0] operation;
        logic       cin;
        logic       known;      // code is one of the six defined operations
    } slice_ctrl_t;

    // Map an ALU_control code onto slice controls; unknown codes use the AND decode.
    function automatic slice_ctrl_t decode_ctrl(logic [3:0] code);
        slice_ctrl_t c;
        c.a_invert  = 1'b0;
        c.b_invert  = 1'b0;
        c.operation = 2'b00;
        c.cin       = 1'b0;
        c.known     = 1'b1;
        case (code)
            AluAnd: c.operation = 2'b00;
            AluOr:  c.operation = 2'b01;
            AluAdd: c.operation = 2'b10;
            AluSub, AluSlt: begin
                c.b_invert  = 1'b1;
                c.operation = 2'b10;
                c.cin       = 1'b1;
            end
            AluNor: begin
                c.a_invert = 1'b1;
                c.b_invert = 1'b1;
            end
            default: c.known = 1'b0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/alu4.sv
// 4-bit ALU slice: optional operand inversion, AND/OR/ADD/LESS select, carry in/out.
module alu4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       a_invert,
    input  logic       b_invert,
    input  logic [1:0] operation,
    input  logic       cin,
    input  logic       less,
    output logic [3:0] result,
    output logic       cout
);

    logic [3:0] ai;
    logic [3:0] bi;
    logic [4:0] sum;

    // Invert, add and select the slice output.
    always_comb begin
        ai   = a ^ {4{a_invert}};
        bi   = b ^ {4{b_invert}};
        sum  = {1'b0, ai} + {1'b0, bi} + {4'b0000, cin};
        cout = sum[4];
        case (operation)
            2'b00:   result = ai & bi;
            2'b01:   result = ai | bi;
            2'b10:   result = sum[3:0];
            default: result = {3'b000, less};
        endcase
    end

endmodule

// File: rtl/alu32_seq.sv
// 32-bit ALU that runs one 4-bit slice over eight nibbles, LSB first, chaining the carry.
module alu32_seq
    import alu_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    output logic        ready,
    input  logic [31:0] src1,
    input  logic [31:0] src2,
    input  logic [3:0]  ALU_control,
    output logic [31:0] result,
    output logic        zero,
    output logic        cout,
    output logic        overflow,
    output logic        valid
);

    state_e      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic        carry_q, carry_d;
    logic [31:0] acc_q, acc_d;
    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;
    logic [3:0]  op_q, op_d;
    logic [31:0] result_q, result_d;
    logic        zero_q, zero_d;
    logic        cout_q, cout_d;
    logic        ovf_q, ovf_d;

    slice_ctrl_t ctrl;
    logic [3:0]  slice_res;
    logic        slice_cout;
    logic        a31, b31, sum31, ovf_calc;

    assign ctrl = decode_ctrl(op_q);

    alu4 u_slice (
        .a         (a_q[{cnt_q, 2'b00} +: 4]),
        .b         (b_q[{cnt_q, 2'b00} +: 4]),
        .a_invert  (ctrl.a_invert),
        .b_invert  (ctrl.b_invert),
        .operation (ctrl.operation),
        .cin       (carry_q),
        .less      (1'b0),
        .result    (slice_res),
        .cout      (slice_cout)
    );

    // Sign bits of the effective operands and the sum bit 31 seen on the last nibble.
    always_comb begin
        a31      = a_q[31] ^ ctrl.a_invert;
        b31      = b_q[31] ^ ctrl.b_invert;
        sum31    = slice_res[3];
        ovf_calc = (a31 == b31) && (sum31 != a31);
    end

    // Sequencing, accumulation and final flag/result fix-up.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        carry_d  = carry_q;
        acc_d    = acc_q;
        a_d      = a_q;
        b_d      = b_q;
        op_d     = op_q;
        result_d = result_q;
        zero_d   = zero_q;
        cout_d   = cout_q;
        ovf_d    = ovf_q;
        case (state_q)
            StIdle: begin
                if (start) begin
                    a_d     = src1;
                    b_d     = src2;
                    op_d    = ALU_control;
                    cnt_d   = 3'd0;
                    carry_d = decode_ctrl(ALU_control).cin;
                    state_d = StRun;
                end
            end
            StRun: begin
                acc_d[{cnt_q, 2'b00} +: 4] = slice_res;
                carry_d = slice_cout;
                cnt_d   = cnt_q + 3'd1;
                if (cnt_q == 3'(NIBBLES - 1)) begin
                    state_d = StDone;
                    case (op_q)
                        AluAdd, AluSub: begin
                            result_d = acc_d;
                            cout_d   = slice_cout;
                            ovf_d    = ovf_calc;
                        end
                        AluSlt: begin
                            result_d = {31'b0, sum31 ^ ovf_calc};
                            cout_d   = slice_cout;
                            ovf_d    = ovf_calc;
                        end
                        default: begin
                            // Logical ops report no carry/overflow; unknown codes yield zero.
                            result_d = ctrl.known ? acc_d : 32'h0;
                            cout_d   = 1'b0;
                            ovf_d    = 1'b0;
                        end
                    endcase
                    zero_d = (result_d == 32'h0);
                end
            end
            StDone: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            cnt_q    <= 3'd0;
            carry_q  <= 1'b0;
            acc_q    <= 32'h0;
            a_q      <= 32'h0;
            b_q      <= 32'h0;
            op_q     <= 4'h0;
            result_q <= 32'h0;
            zero_q   <= 1'b0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            carry_q  <= carry_d;
            acc_q    <= acc_d;
            a_q      <= a_d;
            b_q      <= b_d;
            op_q     <= op_d;
            result_q <= result_d;
            zero_q   <= zero_d;
            cout_q   <= cout_d;
            ovf_q    <= ovf_d;
        end
    end

    assign ready    = (state_q == StIdle);
    assign valid    = (state_q == StDone);
    assign result   = result_q;
    assign zero     = zero_q;
    assign cout     = cout_q;
    assign overflow = ovf_q;

endmodule

// File: tb/tb_alu32_seq.sv
// Bench for alu32_seq: directed vector table, randomized ops against a 32-bit arithmetic model,
// and hand-written handshake/reset sequences.
module tb_alu32_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [31:0] src1 = 32'h0;
    logic [31:0] src2 = 32'h0;
    logic [3:0]  ALU_control = 4'h0;
    logic        ready;
    logic [31:0] result;
    logic        zero;
    logic        cout;
    logic        overflow;
    logic        valid;

    alu32_seq dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .ready       (ready),
        .src1        (src1),
        .src2        (src2),
        .ALU_control (ALU_control),
        .result      (result),
        .zero        (zero),
        .cout        (cout),
        .overflow    (overflow),
        .valid       (valid)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        z;
        logic        c;
        logic        o;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(logic [3:0] op, logic [31:0] a, logic [31:0] b,
                                logic [31:0] res, logic z, logic c, logic o);
        vec_t v;
        v.op = op; v.a = a; v.b = b; v.res = res; v.z = z; v.c = c; v.o = o;
        return v;
    endfunction

    // Reference: plain 33-bit arithmetic and signed compare.
    function automatic vec_t model(logic [3:0] op, logic [31:0] a, logic [31:0] b);
        vec_t v;
        logic [32:0] s;
        v.op = op; v.a = a; v.b = b; v.c = 1'b0; v.o = 1'b0;
        case (op)
            4'b0000: v.res = a & b;
            4'b0001: v.res = a | b;
            4'b1100: v.res = ~(a | b);
            4'b0010: begin
                s = {1'b0, a} + {1'b0, b};
                v.res = s[31:0];
                v.c = s[32];
                v.o = (a[31] == b[31]) && (s[31] != a[31]);
            end
            4'b0110, 4'b0111: begin
                s = {1'b0, a} + {1'b0, ~b} + 33'd1;
                v.c = s[32];
                v.o = (a[31] != b[31]) && (s[31] != a[31]);
                if (op == 4'b0110) v.res = s[31:0];
                else v.res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            end
            default: v.res = 32'h0;
        endcase
        v.z = (v.res == 32'h0);
        return v;
    endfunction

    // Issue one op, follow 12 edges after acceptance, check handshake timing, return outputs.
    task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b, input bit mid_start,
                          output logic [31:0] res, output logic z, output logic c,
                          output logic o);
        int first_k = -1;
        int n_valid = 0;
        bit ready_bad = 0;
        bit held_bad = 0;
        logic [31:0] prev;
        @(negedge clk);
        start = 1'b1; src1 = a; src2 = b; ALU_control = op;
        @(posedge clk);
        #1;
        start = 1'b0;
        src1 = $urandom; src2 = $urandom; ALU_control = 4'($urandom);
        res = result; z = zero; c = cout; o = overflow;
        for (int k = 1; k <= 12; k++) begin
            @(posedge clk);
            #1;
            if (valid === 1'b1) begin
                n_valid++;
                if (first_k < 0) begin
                    first_k = k;
                    res = result; z = zero; c = cout; o = overflow;
                end
            end
            if (k <= 8 && ready !== 1'b0) ready_bad = 1;
            if (k >= 9 && ready !== 1'b1) ready_bad = 1;
            if (k == 1) prev = result;
            if (k == 7 && result !== prev) held_bad = 1;
            if (mid_start && k == 2) start = 1'b1;
            if (k == 3) start = 1'b0;
        end
        check({tag, " valid_edge"}, first_k, 8);
        check({tag, " valid_count"}, n_valid, 1);
        check({tag, " ready_window"}, {31'b0, ready_bad}, 32'd0);
        check({tag, " outputs_held"}, {31'b0, held_bad}, 32'd0);
    endtask

    task automatic run_and_check(input string tag, input vec_t v, input bit mid_start);
        logic [31:0] r;
        logic z, c, o;
        run_op(tag, v.op, v.a, v.b, mid_start, r, z, c, o);
        check({tag, " result"}, r, v.res);
        check({tag, " zero"}, {31'b0, z}, {31'b0, v.z});
        check({tag, " cout"}, {31'b0, c}, {31'b0, v.c});
        check({tag, " overflow"}, {31'b0, o}, {31'b0, v.o});
    endtask

    initial begin
        vec_t tbl[10];
        logic [3:0] ops[8];
        logic [31:0] edge_vals[6];
        int bad;
        int nv;

        tbl[0] = mk(4'b0010, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 0, 0, 1);
        tbl[1] = mk(4'b0110, 32'h00000005, 32'h00000005, 32'h00000000, 1, 1, 0);
        tbl[2] = mk(4'b0111, 32'hFFFFFFFF, 32'h00000001, 32'h00000001, 0, 1, 0);
        tbl[3] = mk(4'b0111, 32'h7FFFFFFF, 32'h80000000, 32'h00000000, 1, 0, 1);
        tbl[4] = mk(4'b1100, 32'h0F0F0000, 32'h00F00000, 32'hF000FFFF, 0, 0, 0);
        tbl[5] = mk(4'b0000, 32'h0F0F0000, 32'h00F00000, 32'h00000000, 1, 0, 0);
        tbl[6] = mk(4'b0001, 32'h0F0F0000, 32'h00F00000, 32'h0FFF0000, 0, 0, 0);
        tbl[7] = mk(4'b0010, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1, 1, 0);
        tbl[8] = mk(4'b0011, 32'h12345678, 32'h0F0F0F0F, 32'h00000000, 1, 0, 0);
        tbl[9] = mk(4'b0110, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 0, 1, 1);

        ops[0] = 4'b0000; ops[1] = 4'b0001; ops[2] = 4'b0010; ops[3] = 4'b0110;
        ops[4] = 4'b0111; ops[5] = 4'b1100; ops[6] = 4'b0011; ops[7] = 4'b1111;
        edge_vals[0] = 32'h0;        edge_vals[1] = 32'hFFFFFFFF; edge_vals[2] = 32'h7FFFFFFF;
        edge_vals[3] = 32'h80000000; edge_vals[4] = 32'h00000001; edge_vals[5] = 32'h0000000F;

        // Reset state
        #12;
        check("reset ready", {31'b0, ready}, 32'd1);
        check("reset valid", {31'b0, valid}, 32'd0);
        check("reset result", result, 32'h0);
        check("reset flags", {29'b0, zero, cout, overflow}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 10; i++) begin
            run_and_check($sformatf("vec%0d", i), tbl[i], i == 3);
        end

        for (int i = 0; i < 40; i++) begin
            logic [31:0] a, b;
            logic [3:0] op;
            op = ops[$urandom_range(0, 7)];
            a = ($urandom_range(0, 3) == 0) ? edge_vals[$urandom_range(0, 5)] : $urandom;
            b = ($urandom_range(0, 3) == 0) ? edge_vals[$urandom_range(0, 5)] : $urandom;
            run_and_check($sformatf("rnd%0d op%b", i, op), model(op, a, b),
                          $urandom_range(0, 3) == 0);
        end

        // start held high: accepted at E and E+10 only
        @(negedge clk);
        start = 1'b1; src1 = 32'd1; src2 = 32'd2; ALU_control = 4'b0010;
        @(posedge clk);
        #1;
        bad = 0;
        nv = 0;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk);
            #1;
            if (valid === 1'b1) nv++;
            if (valid !== ((k == 8) || (k == 18))) bad++;
        end
        start = 1'b0;
        check("held_start valid_pattern", bad, 0);
        check("held_start valid_count", nv, 2);
        check("held_start result", result, 32'd3);
        repeat (12) @(posedge clk);

        // Leave nonzero outputs, then reset in the middle of an operation.
        run_and_check("pre_reset", model(4'b0010, 32'h7FFFFFFF, 32'h7FFFFFFF), 0);
        @(negedge clk);
        start = 1'b1; src1 = 32'h7FFFFFFF; src2 = 32'h1; ALU_control = 4'b0010;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("midreset ready", {31'b0, ready}, 32'd1);
        check("midreset valid", {31'b0, valid}, 32'd0);
        check("midreset result", result, 32'h0);
        check("midreset flags", {29'b0, zero, cout, overflow}, 32'd0);
        nv = 0;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk);
            #1;
            if (valid === 1'b1) nv++;
            if (k == 2) begin
                @(negedge clk);
                rst_n = 1'b1;
            end
        end
        check("midreset no_valid", nv, 0);
        run_and_check("post_reset add", mk(4'b0010, 32'd2, 32'd3, 32'd5, 0, 0, 0), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/alu32_seq.md
# alu32_seq

Multi-cycle 32-bit ALU controller that time-multiplexes a single 4-bit ALU slice over eight nibbles. It accepts a 32-bit operation through a start/ready handshake and decodes the ALU control code into slice controls. It chains the carry between nibbles, applies the set-on-less-than fix-up after the last nibble, and presents result and flags with a one-cycle valid pulse. It sits between the instruction decode stage and the register write-back and replaces the combinational 32-bit ripple/CLA ALU where area matters more than latency.

## Interface
Parameters:
- none (width fixed at 32 = 8 nibbles of 4 bits)

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  request; accepted only when ready=1
- ready  out  1  high in IDLE only
- src1  in  32  operand A, latched on accept
- src2  in  32  operand B, latched on accept
- ALU_control  in  4  op code, latched on accept: AND 0000, OR 0001, ADD 0010, SUB 0110, SLT 0111, NOR 1100
- result  out  32  registered result, held until next completion
- zero  out  1  result==0, registered with result
- cout  out  1  carry out of bit 31 (ADD/SUB/SLT), else 0
- overflow  out  1  signed overflow (ADD/SUB/SLT), else 0
- valid  out  1  one-cycle completion pulse

## Operation
- States: IDLE, RUN, DONE.
- IDLE -> RUN on start=1: latch src1, src2 and ALU_control, set nibble counter cnt=0, and load the carry register with the decoded cin.
- Decode (A_invert, B_invert, operation, cin):
  - AND 0,0,00,0
  - OR 0,0,01,0
  - ADD 0,0,10,0
  - SUB 0,1,10,1
  - SLT 0,1,10,1 (subtract)
  - NOR 1,1,00,0
- Undefined codes follow AND decode and force result=0.
- RUN, per cycle:
  - drive the slice with nibble cnt of both operands, the carry register and less=0
  - write the slice result into accumulator bits [4cnt+3:4cnt]
  - carry register <= slice cout
  - cnt increments
- RUN -> DONE when cnt=7 is processed. In the same edge, load the outputs from the accumulator:
  - overflow = (a31'==b31') && (sum31!=a31'), where a31' = src1[31]^A_invert and b31' = src2[31]^B_invert
  - cout = final carry
  - SLT: result = {31'b0, sum31 ^ overflow}, zero recomputed from that value; cout and overflow still reported from the subtraction
  - AND/OR/NOR: cout=0, overflow=0
- DONE: valid=1 for exactly one cycle, then unconditionally -> IDLE.
- start while not in IDLE is ignored; it is not queued.
- Operands, op code, result and flags are unaffected by input changes after accept.

## Timing
- start sampled high at edge E.
- Nibble i is captured at edge E+1+i.
- valid is sampled high at edge E+9 only.
- ready is sampled low at edges E+1..E+9 and high again at E+10.
- Back-to-back throughput: one operation per 10 cycles.
- Reset, asynchronous, any state:
  - state=IDLE, ready=1, valid=0
  - result=0, zero=0, cout=0, overflow=0
  - cnt=0, accumulator=0
- Reset mid-RUN aborts the operation: no valid pulse, and outputs return to reset values.
- Outputs change only at the DONE-entry edge or on reset.

## Structure
- Shared package alu_pkg:
  - ALU_control code constants
  - state enum (IDLE/RUN/DONE)
  - NIBBLES=8 constant
- Sub-module: one instance of the team's alu4 slice; all sequencing and decode stay in alu32_seq.
- Carry between nibbles is the only cross-cycle datapath state besides the accumulator.

## Test plan
- ADD 0x7FFFFFFF + 0x00000001 -> result 0x80000000, overflow=1, cout=0, zero=0, valid at E+9.
- SUB 0x00000005 − 0x00000005 -> result 0, zero=1, cout=1, overflow=0.
- SLT 0xFFFFFFFF vs 0x00000001 -> result 1; SLT 0x7FFFFFFF vs 0x80000000 -> result 0 (overflow=1 path).
- NOR 0x0F0F0000, 0x00F00000 -> 0xF000FFFF; AND/OR with the same operands -> 0x00000000 and 0x0FFF0000, cout=0, overflow=0.
- start pulsed at E+3 during RUN -> ignored, exactly one valid; start held high continuously -> operations accepted at E and E+10 only.
- rst_n low at E+4 -> no valid; ready=1 and all outputs 0 immediately; a new ADD 2+3 after release -> result 5.
